fbcpu_gen2: RTL and testbench

FBCPU_GEN2 -- requirements
Module: fbcpu_gen2

---
 rtl/fbcpu_gen2.sv | 105 ++++++++++
 tb/tb_fbcpu_gen2.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fbcpu_gen2.sv
// fbcpu_gen2: multicycle accumulator CPU with a ready-handshaked memory port.
// Optional C flag (ADD/SUB/SHL/SHR, JC) enabled by defining FBCPU_GEN2_CARRY_EN.
module fbcpu_gen2 #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0]    acc,
  output logic                     halted
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int OW = DW - AW;
  if (OW < 4) begin : g_bad_width
    $error("opcode field must be at least 4 bits wide");
  end
  typedef enum logic [1:0] {FETCH, DECODE, MEM, HALT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, ir_q, ir_d, res;
  logic z_q, c_q, wr;
  logic [OW-1:0] op;
  logic [AW-1:0] opd;
  logic is_mem, active;
  assign op = ir_q[DW-1:AW];
  assign opd = ir_q[AW-1:0];
  assign is_mem = op >= OW'(1) && op <= OW'(6);
  // Shared result path: MEM-completed ALU ops and DECODE-time LDI/SHL/SHR
  always_comb begin
    res = op == OW'(1)  ? mem_rdata :
          op == OW'(3)  ? acc_q + mem_rdata :
          op == OW'(4)  ? acc_q - mem_rdata :
          op == OW'(5)  ? acc_q & mem_rdata :
          op == OW'(6)  ? acc_q | mem_rdata :
          op == OW'(10) ? {{OW{1'b0}}, opd} :
          op == OW'(11) ? acc_q << 1 :
          op == OW'(12) ? acc_q >> 1 : acc_q;
    wr = (state_q == MEM && mem_ready && op != OW'(2)) ||
         (state_q == DECODE && op >= OW'(10) && op <= OW'(12));
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    case (state_q)
      FETCH: if (mem_ready) begin
        ir_d = mem_rdata;
        pc_d = pc_q + AW'(1);
        state_d = DECODE;
      end
      DECODE: begin
        state_d = is_mem ? MEM : op == OW'(15) ? HALT : FETCH;
        pc_d = (op == OW'(7) || (op == OW'(8) && z_q) || (op == OW'(9) && c_q)) ? opd : pc_q;
      end
      MEM: state_d = mem_ready ? FETCH : MEM;
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= '0;
      acc_q <= '0;
      ir_q <= '0;
      z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      if (wr) begin
        acc_q <= res;
        z_q <= res == '0;
      end
    end
  end
`ifdef FBCPU_GEN2_CARRY_EN
  logic c_d;
  // ADD carries out exactly when the wrapped sum is below the old ACC
  always_comb
    c_d = (state_q == MEM && mem_ready && op == OW'(3)) ? res < acc_q :
          (state_q == MEM && mem_ready && op == OW'(4)) ? acc_q < mem_rdata :
          (state_q == DECODE && op == OW'(11)) ? acc_q[DW-1] :
          (state_q == DECODE && op == OW'(12)) ? acc_q[0] : c_q;
  always_ff @(posedge clk)
    c_q <= rst ? 1'b0 : c_d;
`else
  assign c_q = 1'b0;
`endif
  assign active = !rst && (state_q == FETCH || state_q == MEM);
  assign mem_req = active;
  assign mem_addr = !active ? '0 : state_q == FETCH ? pc_q : opd;
  assign mem_we = active && state_q == MEM && op == OW'(2);
  assign mem_wdata = mem_we ? acc_q : '0;
  assign pc = pc_q;
  assign acc = acc_q;
  assign halted = !rst && state_q == HALT;
endmodule

// File: tb/tb_fbcpu_gen2.sv
// tb_fbcpu_gen2: directed programs against a bench-side memory with configurable wait states.
module tb_fbcpu_gen2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_req, mem_we, mem_ready, halted;
  logic [5:0] mem_addr, pc;
  logic [9:0] mem_wdata, mem_rdata, acc;
  logic [9:0] mem [64];
  int wait_n = 0, wcnt = 0, n_cmp = 0, n_bad = 0;
  bit hold = 1'b0, prev_wait = 1'b0;
  logic [5:0] p_addr;
  logic p_we;
  logic [9:0] p_wdata;
  always #5 clk = ~clk;
  assign mem_ready = mem_req && !hold && wcnt >= wait_n;
  assign mem_rdata = mem[mem_addr];
  fbcpu_gen2 dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .acc(acc), .halted(halted)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] ins(input int o, input int a);
    return 10'((o << 6) | a);
  endfunction
  task automatic clear();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask
  // One clock: check wait-state stability, then apply the write and wait counter after the edge
  task automatic tick();
    logic w, done, waiting;
    logic [5:0] a;
    logic [9:0] d;
    w = mem_req && mem_we && mem_ready;
    done = mem_req && mem_ready;
    waiting = mem_req && !mem_ready;
    a = mem_addr;
    d = mem_wdata;
    if (waiting && prev_wait) begin
      chk("stable_addr", 32'(mem_addr), 32'(p_addr));
      chk("stable_we", 32'(mem_we), 32'(p_we));
      chk("stable_wdata", 32'(mem_wdata), 32'(p_wdata));
    end
    prev_wait = waiting;
    p_addr = mem_addr;
    p_we = mem_we;
    p_wdata = mem_wdata;
    @(posedge clk);
    #1;
    if (w) mem[a] = d;
    wcnt = done ? 0 : waiting ? wcnt + 1 : 0;
    @(negedge clk);
  endtask
  task automatic start();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("fetch0_req", 32'(mem_req), 1);
    chk("fetch0_addr", 32'(mem_addr), 0);
    chk("fetch0_we", 32'(mem_we), 0);
  endtask
  task automatic run_to_halt(input int bound);
    int n = 0;
    while (!halted && n < bound) begin
      tick();
      n++;
    end
    chk("halt_reached", 32'(halted), 1);
  endtask
  initial begin
    @(negedge clk);
    clear();
    tick();
    tick();
    chk("rst_pc", 32'(pc), 0);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    mem[0] = ins(10, 5);
    mem[1] = ins(3, 20);
    mem[2] = ins(2, 21);
    mem[3] = ins(15, 0);
    mem[20] = 10'd7;
    start();
    tick();
    chk("ldi_pc", 32'(pc), 1);
    tick();
    chk("ldi_acc", 32'(acc), 5);
    chk("ldi_next_fetch", 32'(mem_addr), 1);
    run_to_halt(20);
    chk("prog_mem21", 32'(mem[21]), 12);
    chk("prog_acc", 32'(acc), 12);
    chk("prog_pc", 32'(pc), 4);
    for (int i = 0; i < 3; i++) tick();
    chk("halt_pc_frozen", 32'(pc), 4);
    chk("halt_acc_frozen", 32'(acc), 12);
    chk("halt_no_req", 32'(mem_req), 0);
    chk("halt_held", 32'(halted), 1);
    mem[21] = '0;
    wait_n = 3;
    start();
    run_to_halt(60);
    chk("wait_mem21", 32'(mem[21]), 12);
    chk("wait_acc", 32'(acc), 12);
    wait_n = 0;
    clear();
    mem[0] = ins(1, 40);
    mem[1] = ins(3, 41);
    mem[2] = ins(8, 10);
    mem[3] = ins(15, 0);
    mem[10] = ins(9, 20);
    mem[11] = ins(15, 0);
    mem[20] = ins(15, 0);
    mem[40] = 10'd1023;
    mem[41] = 10'd1;
    start();
    for (int i = 0; i < 6; i++) tick();
    chk("add_wrap_acc", 32'(acc), 0);
    run_to_halt(20);
`ifdef FBCPU_GEN2_CARRY_EN
    chk("jz_jc_pc", 32'(pc), 21);
`else
    chk("jz_jc_pc", 32'(pc), 12);
`endif
    clear();
    mem[0] = ins(7, 63);
    start();
    tick();
    tick();
    chk("jmp_pc", 32'(pc), 63);
    tick();
    chk("pc_wrap", 32'(pc), 0);
    tick();
    chk("wrap_fetch_addr", 32'(mem_addr), 0);
    chk("wrap_fetch_req", 32'(mem_req), 1);
    clear();
    mem[0] = ins(10, 3);
    mem[1] = ins(14, 5);
    mem[2] = ins(4, 40);
    mem[3] = ins(9, 10);
    mem[4] = ins(15, 0);
    mem[10] = ins(15, 0);
    mem[40] = 10'd5;
    start();
    for (int i = 0; i < 4; i++) tick();
    chk("opE_acc", 32'(acc), 3);
    chk("opE_pc", 32'(pc), 2);
    run_to_halt(20);
    chk("sub_acc", 32'(acc), 1022);
`ifdef FBCPU_GEN2_CARRY_EN
    chk("sub_borrow_pc", 32'(pc), 11);
`else
    chk("sub_borrow_pc", 32'(pc), 5);
`endif
    clear();
    mem[0] = ins(1, 40);
    mem[1] = ins(5, 41);
    mem[2] = ins(6, 42);
    mem[3] = ins(11, 0);
    mem[4] = ins(12, 0);
    mem[5] = ins(15, 0);
    mem[40] = 10'd682;
    mem[41] = 10'd240;
    mem[42] = 10'd5;
    start();
    run_to_halt(30);
    chk("logic_shift_acc", 32'(acc), 165);
    clear();
    mem[0] = ins(10, 9);
    mem[1] = ins(1, 40);
    mem[40] = 10'd77;
    start();
    for (int i = 0; i < 4; i++) tick();
    hold = 1'b1;
    #1;
    chk("mem_req_wait", 32'(mem_req), 1);
    chk("mem_addr_operand", 32'(mem_addr), 40);
    chk("pre_rst_acc", 32'(acc), 9);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_req", 32'(mem_req), 0);
    chk("rst_mid_addr", 32'(mem_addr), 0);
    tick();
    rst = 1'b0;
    hold = 1'b0;
    #1;
    chk("post_rst_req", 32'(mem_req), 1);
    chk("post_rst_addr", 32'(mem_addr), 0);
    chk("post_rst_acc", 32'(acc), 0);
    chk("post_rst_pc", 32'(pc), 0);
    tick();
    chk("post_rst_pc1", 32'(pc), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
